// File: rtl/apb_new_slave_pkg.sv
// Shared types and constants for the 16-byte "new slave" APB window.
// Holds the register offsets, CSR bit positions, response FSM states and the registered-state struct.
package apb_new_slave_pkg;

  localparam logic [31:0] CFG_HW_ID = 32'h2022_1101;

  // Word offsets, taken from paddr[3:2]
  localparam logic [1:0] OFF_HWID  = 2'd0;
  localparam logic [1:0] OFF_CSR   = 2'd1;
  localparam logic [1:0] OFF_DATA  = 2'd2;
  localparam logic [1:0] OFF_TIMER = 2'd3;

  localparam int CSR_IRQ_ENA  = 0;
  localparam int CSR_EMPTY    = 1;
  localparam int CSR_FULL     = 2;
  localparam int CSR_IRQ_PEND = 3;
  localparam int CSR_OVF      = 8;
  localparam int CSR_CNT_LSB  = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;

  typedef struct packed {
    state_e      state;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq_ena;
    logic        ovf;
  } regs_t;

  localparam regs_t REGS_RST = '{
    state:   ST_IDLE,
    prdata:  32'h0,
    pready:  1'b0,
    pslverr: 1'b0,
    irq_ena: 1'b0,
    ovf:     1'b0
  };

endpackage

// File: rtl/apb_new_slave_fifo.sv
// Synchronous mailbox FIFO with wrap-around pointers; push when full and pop when empty are ignored.
// The head word is presented combinationally so a read can capture it before the pop commits.
module apb_new_slave_fifo #(
  parameter int LOG2_DEPTH = 2,
  parameter int W          = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        head,
  output logic                full,
  output logic                empty,
  output logic [LOG2_DEPTH:0] count
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;

  logic [W-1:0]            mem [DEPTH];
  logic [LOG2_DEPTH-1:0]   wptr, rptr;
  logic                    do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/apb_new_slave.sv
// APB responder exposing HW ID, a mailbox FIFO and (with APB_NEW_SLAVE_TIMER_EN) a one-shot timer + irq.
// One wait state: response data is registered on access cycle 1, side effects commit at the end of cycle 2.
module apb_new_slave
  import apb_new_slave_pkg::*;
#(
  parameter int          log2_fifo_depth = 2,
  parameter logic [31:0] hw_id           = CFG_HW_ID
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  apb_in_type  i_apbi,
  output apb_out_type o_apbo,
  output logic        o_irq
);
  regs_t r;

  logic                     acc, commit, wr_commit, rd_commit;
  logic [1:0]               woff;
  logic                     push, pop, csr_wr, tmr_wr;
  logic [31:0]              head;
  logic                     full, empty;
  logic [log2_fifo_depth:0] count;
  logic [3:0]               cnt4;
  logic [31:0]              csr_val, timer_val, rdata_c;
  logic                     err_c, irq_pend;
  logic                     unused_bits;

  assign acc       = i_apbi.pselx & i_apbi.penable;
  assign woff      = i_apbi.paddr[3:2];
  assign commit    = (r.state == ST_WAIT) & acc;
  assign wr_commit = commit & i_apbi.pwrite;
  assign rd_commit = commit & ~i_apbi.pwrite;
  assign push      = wr_commit & (woff == OFF_DATA);
  assign pop       = rd_commit & (woff == OFF_DATA);
  assign csr_wr    = wr_commit & (woff == OFF_CSR);
  assign tmr_wr    = wr_commit & (woff == OFF_TIMER);
  assign cnt4      = 4'(count);
  assign unused_bits = ^{i_apbi.paddr[31:4], i_apbi.paddr[1:0], i_apbi.pstrb, i_apbi.pprot};

  apb_new_slave_fifo #(.LOG2_DEPTH(log2_fifo_depth), .W(32)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .push  (push),
    .pop   (pop),
    .wdata (i_apbi.pwdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef APB_NEW_SLAVE_TIMER_EN
  logic [31:0] timer;
  logic        expire;

  // A timer write landing on the 1->0 edge takes precedence and suppresses the irq.
  assign expire = (timer == 32'd1) & ~tmr_wr;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      timer    <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (tmr_wr)              timer <= i_apbi.pwdata;
      else if (timer != '0)    timer <= timer - 1'b1;
      irq_pend <= (irq_pend & ~(csr_wr & i_apbi.pwdata[CSR_IRQ_PEND])) | expire;
    end
  end

  assign timer_val = timer;
  assign o_irq     = irq_pend & r.irq_ena;
`else
  assign irq_pend  = 1'b0;
  assign timer_val = '0;
  assign o_irq     = 1'b0;
`endif

  always_comb begin
    csr_val                         = '0;
    csr_val[CSR_IRQ_ENA]            = r.irq_ena;
    csr_val[CSR_EMPTY]              = empty;
    csr_val[CSR_FULL]               = full;
    csr_val[CSR_IRQ_PEND]           = irq_pend;
    csr_val[CSR_OVF]                = r.ovf;
    csr_val[CSR_CNT_LSB +: 4]       = cnt4;
  end

  always_comb begin
    rdata_c = '0;
    err_c   = 1'b0;
    if (i_apbi.pwrite) begin
      if (woff == OFF_DATA) err_c = full;
    end else begin
      case (woff)
        OFF_HWID:  rdata_c = hw_id;
        OFF_CSR:   rdata_c = csr_val;
        OFF_DATA:  if (empty) err_c = 1'b1; else rdata_c = head;
        OFF_TIMER: rdata_c = timer_val;
        default:   rdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= REGS_RST;
    end else begin
      case (r.state)
        ST_IDLE: if (acc) begin
          r.state   <= ST_WAIT;
          r.pready  <= 1'b1;
          r.prdata  <= rdata_c;
          r.pslverr <= err_c;
        end
        // Response cycle: commit if the master is still there, else abandon.
        ST_WAIT: begin
          r.state   <= acc ? ST_RESP : ST_IDLE;
          r.pready  <= 1'b0;
          r.pslverr <= 1'b0;
          r.prdata  <= '0;
        end
        default: r.state <= ST_IDLE;
      endcase
      if (csr_wr) r.irq_ena <= i_apbi.pwdata[CSR_IRQ_ENA];
      r.ovf <= (r.ovf & ~(csr_wr & i_apbi.pwdata[CSR_OVF])) | (push & full);
    end
  end

  assign o_apbo.prdata  = r.prdata;
  assign o_apbo.pready  = r.pready;
  assign o_apbo.pslverr = r.pslverr;

endmodule

// File: tb/tb_apb_new_slave.sv
// Directed bench for apb_new_slave: HWID, mailbox FIFO, CSR W1C, timer/irq and mid-transfer reset.
// Timer expectations follow APB_NEW_SLAVE_TIMER_EN as seen by this compile.
module tb_apb_new_slave;
  import apb_new_slave_pkg::*;

`ifdef APB_NEW_SLAVE_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk, nrst;
  apb_in_type  apbi;
  apb_out_type apbo;
  logic        irq;
  int          n_chk, n_pass;
  logic [31:0] rd_v;
  logic        er_v;

  apb_new_slave #(.log2_fifo_depth(2), .hw_id(32'h2022_1101)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_apbi (apbi),
    .o_apbo (apbo),
    .o_irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Caller sits just after a posedge; returns just after the commit edge with the bus idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    apbi.paddr   = addr;
    apbi.pwrite  = wr;
    apbi.pwdata  = wdata;
    apbi.pselx   = 1'b1;
    apbi.penable = 1'b0;
    @(posedge clk); #1 apbi.penable = 1'b1;
    @(negedge clk); chk("pready_acc1", 32'(apbo.pready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("pready_acc2", 32'(apbo.pready), 32'd1);
    rdata = apbo.prdata;
    err   = apbo.pslverr;
    @(posedge clk); #1;
    apbi.pselx   = 1'b0;
    apbi.penable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp, input logic experr);
    logic [31:0] d;
    logic        e;
    xfer(1'b0, addr, 32'h0, d, e);
    chk({tag, "_data"}, d, exp);
    chk({tag, "_err"}, 32'(e), 32'(experr));
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic experr);
    logic [31:0] d;
    logic        e;
    xfer(1'b1, addr, data, d, e);
    chk({tag, "_err"}, 32'(e), 32'(experr));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    apbi = '0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", apbo.prdata, 32'h0);
    chk("rst_pready", 32'(apbo.pready), 32'd0);
    chk("rst_pslverr", 32'(apbo.pslverr), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1 nrst = 1'b1;

    rd("hwid", 32'h0, 32'h2022_1101, 1'b0);
    rd("csr_rst", 32'h4, 32'h0000_0002, 1'b0);

    // Mailbox fill, overflow, drain, underflow
    wr("push_a1", 32'h8, 32'hA1, 1'b0);
    wr("push_a2", 32'h8, 32'hA2, 1'b0);
    wr("push_a3", 32'h8, 32'hA3, 1'b0);
    wr("push_a4", 32'h8, 32'hA4, 1'b0);
    rd("csr_full", 32'h4, 32'h0000_4004, 1'b0);
    wr("push_a5", 32'h8, 32'hA5, 1'b1);
    rd("csr_ovf", 32'h4, 32'h0000_4104, 1'b0);
    rd("pop1", 32'h8, 32'hA1, 1'b0);
    rd("pop2", 32'h8, 32'hA2, 1'b0);
    rd("pop3", 32'h8, 32'hA3, 1'b0);
    rd("pop4", 32'h8, 32'hA4, 1'b0);
    rd("pop_empty", 32'h8, 32'h0, 1'b1);
    rd("csr_drained", 32'h4, 32'h0000_0102, 1'b0);
    wr("csr_w1c_ovf", 32'h4, 32'h0000_0100, 1'b0);
    rd("csr_ovf_clr", 32'h4, 32'h0000_0002, 1'b0);

    // HWID is read-only
    wr("hwid_wr", 32'h0, 32'hDEAD_BEEF, 1'b0);
    rd("hwid_keep", 32'h0, 32'h2022_1101, 1'b0);

    // Timer irq exactly five clocks after the load commits
    wr("csr_ena", 32'h4, 32'h0000_0001, 1'b0);
    rd("csr_ena_rd", 32'h4, 32'h0000_0003, 1'b0);
    wr("tmr5", 32'hC, 32'd5, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); chk("irq_t4", 32'(irq), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("irq_t5", 32'(irq), 32'(TMR));
    @(posedge clk); #1;
    rd("csr_pend", 32'h4, TMR ? 32'h0000_000B : 32'h0000_0003, 1'b0);
    wr("csr_w1c_pend", 32'h4, 32'h0000_0009, 1'b0);
    @(negedge clk); chk("irq_cleared", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rd("csr_pend_clr", 32'h4, 32'h0000_0003, 1'b0);

    // Reload lands on the 1->0 edge: write wins, no irq
    wr("tmr3", 32'hC, 32'd3, 1'b0);
    wr("tmr10", 32'hC, 32'd10, 1'b0);
    rd("tmr_rd", 32'hC, TMR ? 32'd9 : 32'd0, 1'b0);
    wr("tmr0", 32'hC, 32'd0, 1'b0);
    rd("csr_no_pend", 32'h4, 32'h0000_0003, 1'b0);
    chk("irq_none", 32'(irq), 32'd0);

    // Reset during the response cycle of a push
    apbi.paddr = 32'h8; apbi.pwrite = 1'b1; apbi.pwdata = 32'hB1;
    apbi.pselx = 1'b1; apbi.penable = 1'b0;
    @(posedge clk); #1 apbi.penable = 1'b1;
    @(posedge clk); #1;
    chk("mid_pready", 32'(apbo.pready), 32'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_prdata", apbo.prdata, 32'h0);
    chk("mid_rst_pready", 32'(apbo.pready), 32'd0);
    chk("mid_rst_pslverr", 32'(apbo.pslverr), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    apbi = '0;
    @(posedge clk); #1 nrst = 1'b1;
    rd("csr_after_rst", 32'h4, 32'h0000_0002, 1'b0);
    rd("pop_after_rst", 32'h8, 32'h0, 1'b1);
    rd("tmr_after_rst", 32'hC, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
